// File: rtl/mem_stage_lsu.sv
// Load/store unit: word-addressed data RAM behind a multi-cycle access FSM with LAT wait states.
// Optional misaligned-access detection is enabled by defining LSU_ALIGN_CHECK_EN.
module mem_stage_lsu #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_wb,
    output logic        out_err
);

    localparam int unsigned LAT_EFF  = (LAT == 0) ? 1 : LAT;
    localparam logic [3:0]  CNT_LOAD = 4'(LAT_EFF - 1);
    localparam logic [5:0]  OP_SW    = 6'b010000;
    localparam logic [5:0]  OP_LW    = 6'b010001;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, state_next;
    logic [3:0]         cnt;
    logic               is_lw;
    logic [ADDR_W-1:0]  idx;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic               in_mem;
    logic               misaligned;
    logic               commit;
    logic               unused_addr_bits;
    logic [31:0]        mem [0:(1<<ADDR_W)-1];

    assign in_mem = (op == OP_SW) || (op == OP_LW);

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = in_mem && (addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Address bits outside the word index are deliberately ignored (accesses alias modulo depth).
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_err   = err_q;

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (in_mem && !misaligned) ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_lw    <= 1'b0;
            idx      <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            out_data <= '0;
            out_wb   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_mem) begin
                            is_lw   <= (op == OP_LW);
                            idx     <= addr[ADDR_W+1:2];
                            wdata_q <= wdata;
                            cnt     <= CNT_LOAD;
                            out_wb  <= (op == OP_LW) && !misaligned;
                            err_q   <= misaligned;
                            if (misaligned) begin
                                out_data <= '0;
                            end
                        end else begin
                            out_data <= wdata;
                            out_wb   <= 1'b1;
                            err_q    <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        out_data <= is_lw ? mem[idx] : wdata_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Store commits only on the final wait cycle, so a reset earlier in ACCESS leaves RAM untouched.
    always_ff @(posedge clk) begin
        if (commit && !is_lw) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit that consumes the ALU outputs (op, computed address, store data) and performs the data-memory access.
- Owns a word-addressed data RAM and a multi-cycle access FSM with programmable wait states.
- Uses valid/ready handshakes on both sides, toward execute and toward writeback.
- Non-memory ops pass through to writeback with one cycle of latency.

Parameters:
- ADDR_W, 8: word-address width; RAM depth = 2**ADDR_W words of 32 bits.
- LAT, 2: access wait cycles for LW/SW. Legal range 1..15; a value of 0 behaves as 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute stage presents an op.
- in_ready  out  1  LSU accepts an op this cycle.
- op  in  6  opcode: 6'b010000 = SW, 6'b010001 = LW, any other = pass-through.
- addr  in  32  byte address (ALU address output).
- wdata  in  32  store data for SW; ALU result for pass-through ops.
- out_valid  out  1  result available to writeback.
- out_ready  in  1  writeback accepts the result.
- out_data  out  32  load data, or the pass-through value.
- out_wb  out  1  register write-back required (LW and pass-through = 1, SW = 0).
- out_err  out  1  misaligned access flag; only driven when the optional feature is enabled.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - in_ready = 1.
  - out_valid = 0, out_data = 0, out_wb = 0, out_err = 0.
  - wait counter = 0.
  - RAM contents are not reset (undefined).
- Word index = addr[ADDR_W+1:2]. Bits above the index are ignored, so accesses alias modulo depth.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: in_ready = 1.
    - On in_valid with SW/LW: latch op, index and wdata, load counter = LAT-1, go to ACCESS.
    - On in_valid with any other op: latch out_data = wdata, out_wb = 1, go to DONE.
  - ACCESS: in_ready = 0. Counter decrements each cycle. On the cycle the counter is 0:
    - SW: RAM[index] <= wdata (commit point).
    - LW: out_data <= RAM[index].
    - Then go to DONE.
  - DONE: out_valid = 1; out_data, out_wb and out_err held stable. When out_ready = 1: clear out_valid and go to IDLE.
- Latency:
  - Pass-through: out_valid is asserted 1 cycle after acceptance.
  - LW/SW: out_valid is asserted LAT+1 cycles after acceptance.
- Throughput: one op in flight at a time. A new op can be accepted in the cycle after the DONE handshake completes.
- SW in DONE: out_data = stored wdata, out_wb = 0.
- LW following SW to the same index returns the stored value. The write has committed before the LW's access begins, so no bypass is needed.
- in_valid while in_ready = 0 is ignored; the upstream stage holds its op.
- Reset during ACCESS: the SW is discarded if its commit cycle has not yet occurred, and the RAM location is unchanged. The FSM returns to IDLE.
- Reset during DONE: the result is dropped and out_valid = 0 immediately (asynchronous).
- out_ready held high in DONE completes the handshake in a single cycle.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - An SW/LW with addr[1:0] != 0 skips ACCESS and goes to DONE the next cycle.
  - out_err = 1 and out_wb = 0.
  - No RAM write occurs; out_data = 0.
  - out_err clears when the DONE handshake completes.
- Undefined:
  - addr[1:0] is ignored and the access proceeds to the word at the index.
  - out_err is tied to 0.

Test Plan:
- Reset, then SW op=6'b010000, addr=32'h10, wdata=32'hDEADBEEF with LAT=2 -> in_ready low 3 cycles; out_valid at accept+3; out_wb=0; out_data=32'hDEADBEEF.
- LW op=6'b010001, addr=32'h10 after that SW -> out_valid at accept+3; out_data=32'hDEADBEEF; out_wb=1.
- Pass-through op=6'b000000, wdata=32'h5 -> out_valid at accept+1; out_data=5; out_wb=1.
- out_ready held low 4 cycles in DONE -> out_valid and out_data stable throughout; in_ready stays 0; new in_valid is ignored until the handshake.
- SW to addr=32'h20 with rst_n pulsed low during ACCESS; subsequent LW of addr=32'h20 -> data differs from the aborted store (RAM pre-loaded with 32'h1 by an earlier SW); out_valid=0 during reset.
- With LSU_ALIGN_CHECK_EN: LW addr=32'h13 -> out_valid at accept+1; out_err=1; out_wb=0; out_data=0. Without the macro: the same LW reads word index 4 and out_err=0.
